mips_bus_arbiter: RTL and testbench

Shares the CPU's single Avalon memory-mapped master port between two requesters: instruction fetch (port I) and load/store data access (port D). Arbitrates round-robin, registers the winning request onto the bus, and holds it stable through `waitrequest`. Returns a one-cycle acknowledge with captured read data. An optional stall watchdog aborts transfers that never complete. Sits between the CPU core's fetch/memory sequencing and the top-level bus pins.

---
 rtl/mips_bus_arbiter_pkg.sv | 17 +
 rtl/mips_bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_bus_arbiter_pkg.sv
// Shared types and constants for the two-port Avalon bus arbiter.
package mips_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUS,
        ARB_DONE
    } arb_state_t;

    typedef enum logic {
        ARB_PORT_I,
        ARB_PORT_D
    } arb_port_t;

    localparam logic [3:0] ARB_FETCH_BE = 4'b1111;

endpackage

// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon master between instruction fetch (I)
// and load/store (D); registered bus outputs, one-cycle acks, optional stall watchdog.
module mips_bus_arbiter
    import mips_bus_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic        i_ack,
    output logic [31:0] i_readdata,

    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_ack,
    output logic [31:0] d_readdata,

    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,

    output logic        bus_error
);

    localparam logic [15:0] WAIT_LIMIT_W = 16'(WAIT_LIMIT);
    localparam bit          WATCHDOG_EN  = (WAIT_LIMIT != 0);

    arb_state_t  state_q, state_d;
    arb_port_t   grant_q, grant_d;
    arb_port_t   last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        bus_error_q, bus_error_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    logic        i_req;
    logic        d_req;
    arb_port_t   winner;
    logic        finish;
    logic [31:0] finish_data;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        read_d       = read_q;
        write_d      = write_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        bus_error_d  = bus_error_q;
        wait_cnt_d   = wait_cnt_q;
        i_req        = i_read;
        d_req        = d_read | d_write;
        winner       = ARB_PORT_I;
        finish       = 1'b0;
        finish_data  = '0;

        if (i_req && d_req) begin
            winner = (last_grant_q == ARB_PORT_D) ? ARB_PORT_I : ARB_PORT_D;
        end else if (d_req) begin
            winner = ARB_PORT_D;
        end

        case (state_q)
            ARB_IDLE: begin
                if (i_req || d_req) begin
                    state_d      = ARB_BUS;
                    grant_d      = winner;
                    last_grant_d = winner;
                    wait_cnt_d   = '0;
                    if (winner == ARB_PORT_I) begin
                        addr_d  = i_address;
                        be_d    = ARB_FETCH_BE;
                        read_d  = 1'b1;
                        write_d = 1'b0;
                    end else begin
                        // A simultaneous read+write is issued as the write only.
                        addr_d  = d_address;
                        wdata_d = d_writedata;
                        be_d    = d_byteenable;
                        write_d = d_write;
                        read_d  = ~d_write;
                    end
                end
            end
            ARB_BUS: begin
                if (!waitrequest) begin
                    finish = 1'b1;
                    if (read_q) begin
                        finish_data = readdata;
                    end else begin
                        finish_data = (grant_q == ARB_PORT_I) ? i_rdata_q : d_rdata_q;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                    if (WATCHDOG_EN && (wait_cnt_d == WAIT_LIMIT_W)) begin
                        finish      = 1'b1;
                        finish_data = '0;
                        bus_error_d = 1'b1;
                    end
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        // Normal completion and watchdog abort share the same exit into ARB_DONE.
        if (finish) begin
            state_d = ARB_DONE;
            read_d  = 1'b0;
            write_d = 1'b0;
            if (grant_q == ARB_PORT_I) begin
                i_ack_d   = 1'b1;
                i_rdata_d = finish_data;
            end else begin
                d_ack_d   = 1'b1;
                d_rdata_d = finish_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= ARB_PORT_I;
            last_grant_q <= ARB_PORT_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            bus_error_q  <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            read_q       <= read_d;
            write_q      <= write_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            bus_error_q  <= bus_error_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign address    = addr_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = wdata_q;
    assign byteenable = be_q;
    assign i_ack      = i_ack_q;
    assign d_ack      = d_ack_q;
    assign i_readdata = i_rdata_q;
    assign d_readdata = d_rdata_q;
    assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: table-driven single transfers,
// a scoreboard of expected acks, and hand-written tie/watchdog/reset sequences.
module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_read;
    logic [31:0] i_address;
    logic        i_ack;
    logic [31:0] i_readdata;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        d_ack;
    logic [31:0] d_readdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        bus_error;

    mips_bus_arbiter #(.WAIT_LIMIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_ack        (i_ack),
        .i_readdata   (i_readdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_writedata  (d_writedata),
        .d_byteenable (d_byteenable),
        .d_ack        (d_ack),
        .d_readdata   (d_readdata),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .bus_error    (bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        use_i;
        logic        d_rd;
        logic        d_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
        logic [31:0] rdata;
        logic        exp_read;
        logic        exp_write;
        logic [3:0]  exp_be;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic        chk_data;
        logic [31:0] data;
    } sb_item_t;

    vec_t     vecs[6];
    sb_item_t sb[$];
    int       n_checks = 0;
    int       n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ack(input string name);
        sb_item_t e;
        chk1({name, "_ack"}, i_ack | d_ack, 1'b1);
        chk1({name, "_ack_both"}, i_ack & d_ack, 1'b0);
        if ((i_ack | d_ack) && (sb.size() > 0)) begin
            e = sb.pop_front();
            chk1({name, "_port"}, d_ack, e.is_d);
            if (e.chk_data) begin
                chk({name, "_rdata"}, e.is_d ? d_readdata : i_readdata, e.data);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        sb_item_t e;
        i_read       = v.use_i;
        i_address    = v.addr;
        d_read       = v.d_rd;
        d_write      = v.d_wr;
        d_address    = v.addr;
        d_writedata  = v.wdata;
        d_byteenable = v.be;
        e.is_d     = ~v.use_i;
        e.chk_data = v.exp_read;
        e.data     = v.rdata;
        sb.push_back(e);
        step();
        for (int k = 0; k <= v.waits; k++) begin
            chk1({name, "_read"}, read, v.exp_read);
            chk1({name, "_write"}, write, v.exp_write);
            chk({name, "_addr"}, address, v.addr);
            chk({name, "_be"}, {28'b0, byteenable}, {28'b0, v.exp_be});
            if (v.exp_write) chk({name, "_wdata"}, writedata, v.wdata);
            chk1({name, "_early_ack"}, i_ack | d_ack, 1'b0);
            // Scramble live inputs: the bus must keep the latched values.
            i_address   = ~v.addr;
            d_address   = ~v.addr;
            d_writedata = ~v.wdata;
            waitrequest = (k < v.waits);
            readdata    = (k < v.waits) ? ~v.rdata : v.rdata;
            step();
        end
        chk1({name, "_read_drop"}, read, 1'b0);
        chk1({name, "_write_drop"}, write, 1'b0);
        check_ack(name);
        i_read      = 1'b0;
        d_read      = 1'b0;
        d_write     = 1'b0;
        waitrequest = 1'b0;
        step();
        chk1({name, "_ack_pulse"}, i_ack | d_ack, 1'b0);
        chk1({name, "_idle_strobe"}, read | write, 1'b0);
    endtask

    initial begin
        sb_item_t e;
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'hBFC00000, 32'h0,        4'h3, 0, 32'h3C1D0001, 1'b1, 1'b0, 4'hF};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h00001000, 32'hDEADBEEF, 4'h3, 3, 32'h0,        1'b0, 1'b1, 4'h3};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h00002004, 32'h0,        4'hC, 1, 32'h12345678, 1'b1, 1'b0, 4'hC};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h00003000, 32'hCAFEF00D, 4'hF, 0, 32'h0,        1'b0, 1'b1, 4'hF};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h00400010, 32'h0,        4'h0, 2, 32'h8FBF0014, 1'b1, 1'b0, 4'hF};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h00002008, 32'h0,        4'h1, 0, 32'hA5A5A5A5, 1'b1, 1'b0, 4'h1};

        reset = 1'b1; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
        d_address = '0; d_writedata = '0; d_byteenable = '0; waitrequest = 1'b0; readdata = '0;
        step();
        step();
        chk1("rst_read", read, 1'b0);
        chk1("rst_write", write, 1'b0);
        chk1("rst_acks", i_ack | d_ack, 1'b0);
        chk1("rst_bus_error", bus_error, 1'b0);
        chk("rst_address", address, 32'h0);
        chk("rst_writedata", writedata, 32'h0);
        chk("rst_i_readdata", i_readdata, 32'h0);
        chk("rst_d_readdata", d_readdata, 32'h0);
        chk({28'b0, byteenable}, 32'h0, 32'h0) ;
        reset = 1'b0;

        // Tie after reset: both held high, grants must alternate I, D, I, D.
        i_read = 1'b1; d_read = 1'b1; i_address = 32'hBFC00100; d_address = 32'h00010000;
        d_byteenable = 4'hF;
        for (int t = 0; t < 4; t++) begin
            step();
            chk("tie_addr", address, (t % 2 == 1) ? 32'h00010000 : 32'hBFC00100);
            chk1("tie_read", read, 1'b1);
            waitrequest = 1'b0;
            readdata    = 32'h1000 + 32'(t);
            e.is_d = (t % 2 == 1); e.chk_data = 1'b1; e.data = 32'h1000 + 32'(t);
            sb.push_back(e);
            step();
            check_ack("tie");
            step();
        end
        i_read = 1'b0; d_read = 1'b0;
        step();

        for (int v = 0; v < 6; v++) begin
            run_vec(vecs[v], $sformatf("vec%0d", v));
        end

        // Watchdog: waitrequest stuck high on a D read aborts after 4 stalls.
        d_read = 1'b1; d_address = 32'h00005000; d_byteenable = 4'hF;
        waitrequest = 1'b1; readdata = 32'hFFFFFFFF;
        e.is_d = 1'b1; e.chk_data = 1'b1; e.data = 32'h0;
        sb.push_back(e);
        step();
        for (int k = 0; k < 4; k++) begin
            chk1("wd_strobe", read, 1'b1);
            chk1("wd_err_early", bus_error, 1'b0);
            step();
        end
        chk1("wd_strobe_drop", read, 1'b0);
        check_ack("wd");
        chk1("wd_bus_error", bus_error, 1'b1);
        d_read = 1'b0; waitrequest = 1'b0;
        step();
        run_vec(vecs[0], "post_wd");
        chk1("wd_sticky", bus_error, 1'b1);

        // Reset during ARB_BUS loses the transfer; next tie goes to I.
        i_read = 1'b1; i_address = 32'h00400020; waitrequest = 1'b1;
        step();
        chk1("rmid_strobe", read, 1'b1);
        reset = 1'b1;
        step();
        chk1("rmid_read", read, 1'b0);
        chk1("rmid_write", write, 1'b0);
        chk1("rmid_ack", i_ack | d_ack, 1'b0);
        chk1("rmid_bus_error", bus_error, 1'b0);
        reset = 1'b0; i_read = 1'b0; waitrequest = 1'b0;
        step();
        chk1("rmid_ack2", i_ack | d_ack, 1'b0);
        i_read = 1'b1; d_read = 1'b1; i_address = 32'hBFC00200; d_address = 32'h00020000;
        step();
        chk("rmid_tie_addr", address, 32'hBFC00200);
        readdata = 32'h600D600D;
        e.is_d = 1'b0; e.chk_data = 1'b1; e.data = 32'h600D600D;
        sb.push_back(e);
        step();
        check_ack("rmid_tie");
        i_read = 1'b0; d_read = 1'b0;
        step();
        step();

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
